// File: rtl/keccak_round_scheduler.sv
// Round/stage sequencer for the Keccak permutation: launches the theta..iota engines in
// order for NROUNDS rounds, with a debug stage mask and a per-stage hang watchdog.
module keccak_round_scheduler #(
  parameter int NROUNDS = 22,
  parameter int RIDX_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        stage_mask,
  input  logic [4:0]        stage_done,
  output logic [4:0]        stage_start,
  output logic [2:0]        stage_idx,
  output logic [RIDX_W-1:0] round_idx,
  output logic              last_round,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(NROUNDS - 1);
  localparam logic [7:0]        WD_LAST  = 8'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [4:0]        mask_q;
  logic [4:0]        mask_nxt;
  logic [2:0]        stage_nxt;
  logic [RIDX_W-1:0] round_nxt;
  logic [7:0]        wd;
  logic [7:0]        wd_nxt;
  logic [7:0]        done_ext;
  logic [3:0]        first_new;
  logic [3:0]        first_cur;
  logic [3:0]        first_up;
  logic              busy_nxt;

  // Lowest enabled stage at or above lo; bit 3 flags that one exists.
  function automatic logic [3:0] first_enabled(input logic [4:0] m, input logic [2:0] lo);
    logic [3:0] r;
    r = 4'd0;
    for (int s = 4; s >= 0; s--) begin
      if (m[s] && (3'(s) >= lo)) r = {1'b1, 3'(s)};
    end
    return r;
  endfunction

  assign done_ext  = {3'b000, stage_done};
  assign first_new = first_enabled(stage_mask, 3'd0);
  assign first_cur = first_enabled(mask_q, 3'd0);
  assign first_up  = first_enabled(mask_q, stage_idx + 3'd1);

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    stage_nxt = stage_idx;
    round_nxt = round_idx;
    wd_nxt    = wd;
    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          mask_nxt  = stage_mask;
          round_nxt = '0;
          stage_nxt = first_new[2:0];
          state_nxt = first_new[3] ? S_LAUNCH : S_DONE;
        end
      end
      S_LAUNCH: begin
        wd_nxt    = 8'd0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wd_nxt = wd + 8'd1;
        if (done_ext[stage_idx]) begin
          state_nxt = S_NEXT;
        end else if (wd == WD_LAST) begin
          state_nxt = S_ERR;
        end
      end
      S_NEXT: begin
        if (first_up[3]) begin
          stage_nxt = first_up[2:0];
          state_nxt = S_LAUNCH;
        end else if (round_idx == LAST_RND) begin
          state_nxt = S_DONE;
        end else begin
          round_nxt = round_idx + RIDX_W'(1);
          stage_nxt = first_cur[2:0];
          state_nxt = S_LAUNCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides both a coincident done and a watchdog expiry.
    if (abort && (state == S_LAUNCH || state == S_WAIT || state == S_NEXT)) begin
      state_nxt = S_IDLE;
      round_nxt = '0;
      stage_nxt = 3'd0;
    end
  end

  assign busy_nxt = (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT) || (state_nxt == S_NEXT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mask_q     <= 5'd0;
      stage_idx  <= 3'd0;
      round_idx  <= '0;
      wd         <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      last_round <= 1'b0;
    end else begin
      state      <= state_nxt;
      mask_q     <= mask_nxt;
      stage_idx  <= stage_nxt;
      round_idx  <= round_nxt;
      wd         <= wd_nxt;
      busy       <= busy_nxt;
      done       <= (state_nxt == S_DONE);
      err        <= (state_nxt == S_ERR);
      last_round <= busy_nxt && (round_nxt == LAST_RND);
    end
  end

  // The launch pulse is decoded, so it still appears in a LAUNCH cycle that is being aborted.
  assign stage_start = (state == S_LAUNCH) ? (5'd1 << stage_idx) : 5'd0;

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// Scoreboard bench for keccak_round_scheduler: a plan model predicts every launch/done/err
// event with its cycle, and an engine model answers launches after a chosen delay.
module tb_keccak_round_scheduler;
  localparam int NR = 2;
  localparam int RW = 2;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [4:0]    stage_mask;
  logic [4:0]    stage_done;
  logic [4:0]    eng_done;
  logic [4:0]    extra_done;
  logic [4:0]    stage_start;
  logic [2:0]    stage_idx;
  logic [RW-1:0] round_idx;
  logic          last_round;
  logic          busy;
  logic          done;
  logic          err;
  logic          noise_en;

  assign stage_done = eng_done | extra_done;

  keccak_round_scheduler #(.NROUNDS(NR), .RIDX_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stage_mask(stage_mask),
    .stage_done(stage_done), .stage_start(stage_start), .stage_idx(stage_idx),
    .round_idx(round_idx), .last_round(last_round), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 0 launch, 1 done, 2 err
    int stg;
    int rnd;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  dq[$];
  int  nvec = 0;
  int  nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int s, input int r, input int c);
    ev_t e;
    e.kind = kind; e.stg = s; e.rnd = r; e.cyc = c;
    sb.push_back(e);
  endtask

  // Expected events for one run whose first cycle after the accepting edge is t0.
  // cut_kind: 0 none, 1 engine hangs at launch cut_at, 2/3/4 run interrupted at cut_at.
  task automatic plan(input logic [4:0] m, input int t0, input int dfix, input int cut_at,
                      input int cut_kind, output int tend);
    int t;
    int k;
    int d;
    int last_s;
    t = t0; k = 0; last_s = 0; tend = t0;
    if (m == 5'd0) begin
      push_ev(1, 0, 0, t0);
      return;
    end
    for (int r = 0; r < NR; r++) begin
      for (int s = 0; s < 5; s++) begin
        if (m[s]) begin
          if (dfix > 0) d = dfix;
          else if ($urandom_range(0, 7) == 0) d = TO;
          else d = $urandom_range(1, 4);
          if (k == cut_at) d = (cut_kind == 1) ? 0 : TO;
          dq.push_back(d);
          push_ev(0, s, r, t);
          if (k == cut_at) begin
            if (cut_kind == 1) begin
              push_ev(2, s, r, t + TO + 1);
              tend = t + TO + 1;
            end else begin
              tend = t;
            end
            return;
          end
          t = t + d + 2;
          last_s = s;
          k++;
        end
      end
    end
    push_ev(1, last_s, NR - 1, t);
    tend = t;
  endtask

  task automatic issue(input logic [4:0] m, input int dfix, input int cut_at,
                       input int cut_kind, output int tend);
    @(negedge clk);
    stage_mask = m;
    start = 1'b1;
    plan(m, cyc + 1, dfix, cut_at, cut_kind, tend);
    @(negedge clk);
    start = 1'b0;
    stage_mask = 5'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stage_start"}, int'(stage_start), 0);
    chk({tag, "_stage_idx"}, int'(stage_idx), 0);
    chk({tag, "_round_idx"}, int'(round_idx), 0);
    chk({tag, "_last_round"}, int'(last_round), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic expect_ev(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    chk("event_stage_idx", int'(stage_idx), e.stg);
    chk("event_round_idx", int'(round_idx), e.rnd);
    if (kind == 0) begin
      chk("launch_stage_start", int'(stage_start), 1 << e.stg);
      chk("launch_last_round", int'(last_round), int'(e.rnd == NR - 1));
      chk("launch_busy", int'(busy), 1);
      chk("launch_err", int'(err), 0);
    end else begin
      chk("end_busy", int'(busy), 0);
      chk("end_last_round", int'(last_round), 0);
      chk("end_err", int'(err), int'(kind == 2));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic err_q;
    err_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        err_q = 1'b0;
      end else begin
        if (stage_start != 5'd0) expect_ev(0);
        if (done) expect_ev(1);
        if (err && !err_q) expect_ev(2);
        err_q = err;
      end
    end
  end

  // Engine model: answers on the d-th WAIT cycle (never when d is 0), optional noise.
  initial begin
    int cur;
    int k;
    int dd;
    logic [4:0] nz;
    cur = -1; k = 0; dd = 0;
    eng_done = 5'd0;
    forever begin
      @(negedge clk);
      nz = noise_en ? 5'($urandom) : 5'd0;
      if (stage_start != 5'd0) begin
        for (int s = 0; s < 5; s++) if (stage_start[s]) cur = s;
        chk("engine_queue_nonempty", int'(dq.size() > 0), 1);
        dd = (dq.size() > 0) ? dq.pop_front() : 1;
        k = 0;
        eng_done = nz;
      end else if (cur >= 0) begin
        k++;
        eng_done = nz & ~(5'd1 << cur);
        if (dd != 0 && k == dd) eng_done[cur] = 1'b1;
      end else begin
        eng_done = nz;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int t;
    int ta;
    int tb_end;
    logic [4:0] m;
    logic [4:0] m2;
    rst = 1'b0; start = 1'b0; abort = 1'b0; stage_mask = 5'd0;
    extra_done = 5'd0; noise_en = 1'b0;
    #8;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b1;

    // All stages, done on the first WAIT cycle.
    issue(5'b11111, 1, -1, 0, t);
    wait_until(t + 2);
    // Sparse mask, done on the second WAIT cycle.
    issue(5'b10101, 2, -1, 0, t);
    wait_until(t + 2);
    // Empty mask: done right after the accepting edge.
    issue(5'b00000, 0, -1, 0, t);
    wait_until(t + 2);
    chk_idle("mask0_after");

    // Stage 2 hangs with noise on the other done lines.
    noise_en = 1'b1;
    issue(5'b10111, 0, 2, 1, t);
    wait_until(t + 1);
    chk("hang_err", int'(err), 1);
    chk("hang_stage_idx", int'(stage_idx), 2);
    chk("hang_busy", int'(busy), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("err_abort_ignored", int'(err), 1);
    issue(5'b11111, 0, -1, 0, t);
    chk("err_cleared", int'(err), 0);
    wait_until(t + 2);

    // Abort in WAIT of round 1 stage 3 with a coincident stage_done.
    issue(5'b11111, 0, 8, 2, t);
    wait_until(t + 1);
    abort = 1'b1;
    extra_done = 5'b01000;
    @(negedge clk);
    abort = 1'b0;
    extra_done = 5'd0;
    chk_idle("abort_wait");
    wait_until(cyc + TO + 4);

    // Abort in a LAUNCH cycle: the pulse still appears.
    m = 5'($urandom_range(1, 31));
    issue(m, 0, $urandom_range(0, $countones(m) * NR - 1), 3, t);
    wait_until(t);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort_launch");
    wait_until(cyc + TO + 4);

    // Asynchronous reset mid-WAIT in round 1.
    issue(5'b11111, 0, 6, 4, t);
    wait_until(t + 1);
    #2 rst = 1'b0;
    #1 chk_idle("async_reset");
    @(negedge clk);
    rst = 1'b1;
    issue(5'b11111, 0, -1, 0, t);
    wait_until(t + 2);

    // Start held through DONE and three cycles after: one extra run from IDLE.
    m = 5'b11011;
    m2 = 5'b00110;
    @(negedge clk);
    stage_mask = m;
    start = 1'b1;
    plan(m, cyc + 1, 0, -1, 0, ta);
    plan(m2, ta + 2, 0, -1, 0, tb_end);
    wait_until(ta);
    stage_mask = m2;
    wait_until(ta + 4);
    start = 1'b0;
    wait_until(tb_end + 2);

    // Random masks and delays, with stray start pulses while busy and in DONE.
    for (int i = 0; i < 8; i++) begin
      m = 5'($urandom_range(1, 31));
      issue(m, 0, -1, 0, t);
      while (cyc <= t) begin
        start = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      wait_until(t + 2);
    end

    wait_until(cyc + 4);
    chk("scoreboard_drained", sb.size(), 0);
    chk("delay_queue_drained", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/keccak_round_scheduler.md
Name: keccak_round_scheduler

Overview:
- Top-level sequencer for the permutation datapath: runs NROUNDS rounds, each made of five stage engines in fixed order: theta(0), rho(1), pi(2), chi(3), iota(4).
- Each stage engine has its own line controller. This block issues a one-cycle start pulse to the active engine, grants it the shared state memory, and waits for its done.
- A per-stage watchdog detects a hung engine. A stage mask lets individual stages be skipped for debug.

Parameters:
- NROUNDS, 22, number of rounds per permutation (≥1).
- RIDX_W, 5, width of round_idx (2^RIDX_W ≥ NROUNDS).
- TIMEOUT, 255, maximum WAIT cycles allowed per stage (2..255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- start  input  1  begin permutation; sampled in IDLE/ERR only.
- abort  input  1  cancel the running permutation.
- stage_mask  input  5  bit s=1 enables stage s; captured on accepted start.
- stage_done  input  5  bit s = done pulse/level from engine s.
- stage_start  output  5  one-hot, one-cycle launch pulse.
- stage_idx  output  3  active stage (0..4), also the memory-port owner select.
- round_idx  output  RIDX_W  current round (drives the iota constant index).
- last_round  output  1  round_idx == NROUNDS-1 while busy.
- busy  output  1  high in LAUNCH/WAIT/NEXT.
- done  output  1  one-cycle pulse at permutation completion.
- err  output  1  sticky watchdog error.

Behaviour:
- Reset (rst=0, async): state=IDLE; stage_start=0, stage_idx=0, round_idx=0, last_round=0, busy=0, done=0, err=0; mask register=0, watchdog=0.
- States: IDLE, LAUNCH, WAIT, NEXT, DONE, ERR. Registered Moore outputs except stage_start, which is decoded from state=LAUNCH and stage_idx.
- IDLE:
  - start=1 → capture stage_mask, round_idx=0, stage_idx=lowest enabled stage, go to LAUNCH.
  - If the captured mask is 0, go to DONE instead, with round_idx=0.
- LAUNCH (1 cycle): stage_start[stage_idx]=1, watchdog cleared → WAIT.
- WAIT:
  - stage_done[stage_idx] sampled only here; high → NEXT.
  - Other stage_done bits are ignored. stage_done during LAUNCH is ignored.
  - Watchdog increments each WAIT cycle. If stage_done is still low on the TIMEOUT-th WAIT cycle → ERR.
- NEXT (1 cycle):
  - If an enabled stage exists above stage_idx, select it → LAUNCH.
  - Else, if round_idx == NROUNDS-1 → DONE.
  - Else round_idx+1, stage_idx = lowest enabled stage → LAUNCH.
- DONE (1 cycle): done=1, busy=0 → IDLE. round_idx and stage_idx hold their final values until the next start.
- ERR: err=1, busy=0, holds stage_idx/round_idx of the failed stage. start=1 clears err and starts a fresh run exactly as from IDLE.
- abort=1 in LAUNCH/WAIT/NEXT:
  - Next state is IDLE, round_idx=0, stage_idx=0, no done pulse.
  - If abort coincides with the LAUNCH cycle, the stage_start pulse is still emitted that cycle.
- abort in IDLE/DONE/ERR has no effect. abort and stage_done in the same WAIT cycle: abort wins.
- start while busy is ignored. start in the DONE cycle is ignored.
- Per-stage latency is d+2 cycles, where d ≥ 1 is the WAIT cycle in which done is seen. With all stages enabled the total is Σ(d+2) over 5·NROUNDS stages, then 1 DONE cycle.
- round_idx never wraps: the maximum value is NROUNDS-1.

Test Plan:
- NROUNDS=2, mask=11111, every engine returns done on its 1st WAIT cycle, start pulsed at edge 0:
  - stage_start sequence 00001,00010,00100,01000,10000 repeated twice, spaced 3 cycles apart.
  - done high in cycle 31 only; last_round=1 during cycles 16-30.
- mask=10101, NROUNDS=1, d=2 → stage_start pulses only for stages 0, 2, 4; done in cycle 13; stage_idx never shows 1 or 3.
- TIMEOUT=8, stage 2 never responds → err=1 and busy=0 after 8 WAIT cycles, stage_idx=2, round_idx=0. A following start clears err and run 1 completes normally.
- abort during WAIT of round 1, stage 3 → IDLE next cycle, no done, round_idx=0. A stage_done asserted in the same cycle is ignored.
- rst driven low mid-WAIT, asynchronously between edges → all outputs 0 immediately; after release, start yields a full run.
- start held high through DONE and for 3 cycles after → exactly one extra run begins, from IDLE. mask=00000 → done pulses one cycle after start, with no stage_start.
